// File: rtl/mult_pkg.sv
// Shared constants and types for the
// shift-add multiplier family.
package mult_pkg;

  localparam int MULT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_t;

endpackage

// File: rtl/mult_rs_step.sv
// One shift-add iteration: conditional add
// of mcand into the high half, then shift.
module mult_rs_step
  import mult_pkg::*;
#(
  parameter int W = MULT_W
) (
  input  logic [2*W:0] acc_i,
  input  logic [W-1:0] mcand_i,
  output logic [2*W:0] acc_o
);

  logic [W:0] hi;

  // Add keeps the carry in bit W of hi;
  // the shift pulls a zero into bit 2W.
  always_comb begin
    hi = acc_i[2*W:W];
    if (acc_i[0]) begin
      hi = acc_i[2*W:W] + {1'b0, mcand_i};
    end
    acc_o = {1'b0, hi, acc_i[W-1:1]};
  end

endmodule

// File: rtl/mult_rs_seq.sv
// Sequential right-shift unsigned multiplier
// with request/result valid-ready handshakes.
module mult_rs_seq
  import mult_pkg::*;
#(
  parameter int W = MULT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] s,
  output logic           busy
);

  localparam int CW = $clog2(W) + 1;

  mult_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [2*W:0]  acc_q, acc_d;
  logic [2*W:0]  step_acc;

  mult_rs_step #(
    .W(W)
  ) u_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .acc_o  (step_acc)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

  // Next state; acc clears on the result
  // handshake so s reads 0 while idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          mcand_d = a;
          acc_d   = {{(W+1){1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          acc_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s         = acc_q[2*W-1:0];

endmodule
